hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencing controller for the 5-stage MIPS core, paired with the EX-stage operand forwarding unit. It covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits. It drives the write-enable and flush controls of the PC and the pipeline registers, detects memory timeouts, and keeps saturating stall and flush performance counters.

## Interface
- `MEM_TIMEOUT`, 15: consecutive not-ready memory cycles before fault (≥2).
- `CNT_W`, 16: width of the performance counters.
- `clk`  in  1  core clock; every state change happens on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IdRs`, `IdRt`  in  5 each  source register numbers of the instruction in ID.
- `IdUsesRs`, `IdUsesRt`  in  1 each  the instruction in ID actually reads that source.
- `IdExRt`  in  5  destination of the instruction in EX.
- `IdExMemRead`  in  1  the instruction in EX is a load.
- `ExBranchTaken`  in  1  branch or jump resolved taken in EX this cycle.
- `MemReq`  in  1  the MEM-stage instruction accesses data memory.
- `MemReady`  in  1  data memory completes the access this cycle.
- `pcWrite`, `IfIdWrite`, `IdExWrite`, `ExMemWrite`  out  1 each  register load enables.
- `IfIdFlush`, `IdExFlush`, `MemWbBubble`  out  1 each  load a NOP into that register.
- `memTimeout`  out  1  sticky fault flag.
- `stallCycles`, `flushCount`  out  `CNT_W` each  performance counters.

## Operation
- Load-use hazard is true when all of these hold:
  - `IdExMemRead` = 1;
  - `IdExRt` ≠ 0;
  - (`IdUsesRs` and `IdRs` == `IdExRt`) or (`IdUsesRt` and `IdRt` == `IdExRt`).
- Memory miss is true when `MemReq` = 1 and `MemReady` = 0.
- FSM states:
  - RUN (reset state);
  - MEM_WAIT;
  - FAULT.
- Outputs are Mealy and combinational from the state and current inputs. Default: all four write enables are 1 and all flush/bubble outputs are 0.
- RUN and MEM_WAIT apply the same rules, highest priority first:
  1. Memory miss: freeze. All four write enables are 0 and `MemWbBubble` = 1, so writeback is not repeated. Next state is MEM_WAIT.
  2. `ExBranchTaken`: `IfIdFlush` = 1 and `IdExFlush` = 1; `pcWrite` stays 1 so the PC loads the target. `flushCount` increments. Next state is RUN. A load-use hazard in the same cycle is ignored because ID holds a wrong-path instruction.
  3. Load-use hazard: `pcWrite` = 0, `IfIdWrite` = 0 and `IdExFlush` = 1. Next state is RUN.
  4. Otherwise: defaults apply. Next state is RUN.
- In MEM_WAIT, a cycle with `MemReady` = 1 is evaluated by rules 2–4, so the ready cycle advances the pipe normally.
- FAULT: all write enables are 0, `MemWbBubble` = 1, `memTimeout` = 1. FAULT is left only by `rst`.
- Wait counter (internal):
  - counts consecutive memory-miss cycles;
  - clears to 0 on any cycle without a miss;
  - when a miss occurs while the counter equals `MEM_TIMEOUT`−1, the next state is FAULT.
- `stallCycles` increments on every cycle with `pcWrite` = 0 outside FAULT.
- Both counters saturate at all-ones and never wrap.

## Timing
- All control outputs are valid in the same cycle as the inputs that cause them; there is no registered latency.
- State, the wait counter, the performance counters and `memTimeout` update on the rising edge of `clk`.
- While `rst` = 1:
  - state is RUN, the wait counter is 0, both performance counters are 0, `memTimeout` = 0;
  - all four write enables are 0 and all flush/bubble outputs are 0, so no register moves during reset.
- Asserting `rst` mid-wait or in FAULT returns to RUN immediately (asynchronously).
- A load-use stall lasts exactly 1 cycle, because the load leaves EX in the following cycle.
- A memory wait of N not-ready cycles freezes the pipe for N cycles, with N < `MEM_TIMEOUT`.
- `MEM_TIMEOUT` consecutive misses give `memTimeout` = 1 starting in cycle `MEM_TIMEOUT`+1.
- A simultaneous miss and branch: the freeze wins and `flushCount` does not increment. The branch is re-evaluated when the memory becomes ready, since EX is held.

## Structure
- The shared package `mips_pkg` holds:
  - the `hazard_state_t` enum {RUN, MEM_WAIT, FAULT};
  - a packed `pipe_ctrl_t` struct grouping the 7 control outputs;
  - the constant `REG_ZERO` = 5'd0.
- Sub-module `load_use_detect` is purely combinational and computes the load-use term. It is kept separate so it can be unit-tested alongside the forwarding unit.
- The top level holds the FSM, the wait counter and the performance counters.

## Test plan
- Load-use: `IdExMemRead` = 1, `IdExRt` = 8, `IdRs` = 8, `IdUsesRs` = 1 → for one cycle `pcWrite` = 0, `IfIdWrite` = 0, `IdExFlush` = 1; `stallCycles` = 1. With `IdExRt` = 0 → no stall.
- Branch plus load-use together: `ExBranchTaken` = 1 plus the load-use inputs above → `IfIdFlush` = 1, `IdExFlush` = 1, `pcWrite` = 1; `flushCount` = 1 and `stallCycles` = 0.
- Memory wait: `MemReq` = 1 with `MemReady` = 0 for 3 cycles, then 1 → 3 cycles with all enables 0 and `MemWbBubble` = 1, then normal advance; `stallCycles` = 3.
- Timeout: `MEM_TIMEOUT` = 4 with `MemReady` held at 0 → `memTimeout` = 1 from cycle 5 and stays 1 after `MemReady` rises; `rst` pulse → 0 and state RUN.
- Saturation: `CNT_W` = 4 with 20 forced branch flushes → `flushCount` = 15.
- Reset mid-wait: `rst` asserted during MEM_WAIT → all enables 0 while `rst` is high, all counters 0, RUN after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

    // Sequencing states of the hazard controller.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } hazard_state_t;

    // The seven pipeline control lines, MSB first.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Normal advance: every register loads, nothing is flushed.
    localparam pipe_ctrl_t CTRL_ADVANCE = pipe_ctrl_t'(7'b1111000);
    // Whole pipe held; a NOP enters MEM/WB so writeback is not repeated.
    localparam pipe_ctrl_t CTRL_FREEZE  = pipe_ctrl_t'(7'b0000001);
    // Nothing moves at all (used while reset is held).
    localparam pipe_ctrl_t CTRL_IDLE    = pipe_ctrl_t'(7'b0000000);

    // Saturating increment for the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: the load in EX writes a register the
// instruction in ID actually reads. Register 0 never creates a dependency.
module load_use_detect
    import mips_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rs,
    input  logic       i_id_uses_rt,
    input  logic [4:0] i_id_ex_rt,
    input  logic       i_id_ex_mem_read,
    output logic       o_load_use
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_id_uses_rs && (i_id_rs == i_id_ex_rt);
    assign w_rt_match = i_id_uses_rt && (i_id_rt == i_id_ex_rt);
    assign o_load_use = i_id_ex_mem_read && (i_id_ex_rt != REG_ZERO) &&
                        (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// data-memory waits with timeout, and saturating stall/flush counters.
module hazard_controller
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             IdUsesRs,
    input  logic             IdUsesRt,
    input  logic [4:0]       IdExRt,
    input  logic             IdExMemRead,
    input  logic             ExBranchTaken,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             pcWrite,
    output logic             IfIdWrite,
    output logic             IdExWrite,
    output logic             ExMemWrite,
    output logic             IfIdFlush,
    output logic             IdExFlush,
    output logic             MemWbBubble,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    // The wait counter only has to reach MEM_TIMEOUT-1.
    localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [31:0]       CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

    hazard_state_t     r_state;
    hazard_state_t     w_next_state;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_next;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic              r_mem_timeout;
    pipe_ctrl_t        w_ctrl;
    pipe_ctrl_t        w_ctrl_out;
    logic              w_load_use;
    logic              w_miss;
    logic              w_flush_inc;
    logic              w_stall_inc;

    load_use_detect u_load_use_detect (
        .i_id_rs          (IdRs),
        .i_id_rt          (IdRt),
        .i_id_uses_rs     (IdUsesRs),
        .i_id_uses_rt     (IdUsesRt),
        .i_id_ex_rt       (IdExRt),
        .i_id_ex_mem_read (IdExMemRead),
        .o_load_use       (w_load_use)
    );

    assign w_miss = MemReq && !MemReady;

    // Next state, wait counter and Mealy control outputs by hazard priority.
    always_comb begin
        w_ctrl       = CTRL_ADVANCE;
        w_next_state = r_state;
        w_wait_next  = '0;
        w_flush_inc  = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_miss) begin
                    w_ctrl = CTRL_FREEZE;
                    if (r_wait == WAIT_LAST) begin
                        w_next_state = FAULT;
                    end else begin
                        w_next_state = MEM_WAIT;
                        w_wait_next  = r_wait + WAIT_W'(1);
                    end
                end else if (ExBranchTaken) begin
                    // The ID instruction is wrong-path, so any load-use match is moot.
                    w_ctrl.if_id_flush = 1'b1;
                    w_ctrl.id_ex_flush = 1'b1;
                    w_flush_inc        = 1'b1;
                    w_next_state       = RUN;
                end else if (w_load_use) begin
                    w_ctrl.pc_write    = 1'b0;
                    w_ctrl.if_id_write = 1'b0;
                    w_ctrl.id_ex_flush = 1'b1;
                    w_next_state       = RUN;
                end else begin
                    w_next_state = RUN;
                end
            end
            FAULT: begin
                w_ctrl       = CTRL_FREEZE;
                w_next_state = FAULT;
            end
            default: begin
                // An illegal encoding is treated as a fault rather than guessed at.
                w_ctrl       = CTRL_FREEZE;
                w_next_state = FAULT;
            end
        endcase
    end

    // Hold every register still while reset is asserted.
    always_comb begin
        w_ctrl_out = CTRL_IDLE;
        if (rst) begin
            w_ctrl_out = CTRL_IDLE;
        end else begin
            w_ctrl_out = w_ctrl;
        end
    end

    assign w_stall_inc = !w_ctrl.pc_write && (r_state != FAULT);

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait        <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_wait        <= w_wait_next;
            r_mem_timeout <= (w_next_state == FAULT);
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_inc) begin
                r_stall_cycles <= CNT_W'(sat_inc(32'(r_stall_cycles), CNT_MAX));
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (w_flush_inc) begin
                r_flush_count <= CNT_W'(sat_inc(32'(r_flush_count), CNT_MAX));
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign pcWrite     = w_ctrl_out.pc_write;
    assign IfIdWrite   = w_ctrl_out.if_id_write;
    assign IdExWrite   = w_ctrl_out.id_ex_write;
    assign ExMemWrite  = w_ctrl_out.ex_mem_write;
    assign IfIdFlush   = w_ctrl_out.if_id_flush;
    assign IdExFlush   = w_ctrl_out.id_ex_flush;
    assign MemWbBubble = w_ctrl_out.mem_wb_bubble;
    assign memTimeout  = r_mem_timeout;
    assign stallCycles = r_stall_cycles;
    assign flushCount  = r_flush_count;

endmodule
